// File: rtl/idct_pkg.sv
// Shared definitions for the serial 8x8 inverse DCT: scaled basis table,
// controller states and the round-half-up shift used after each 1-D pass.
package idct_pkg;

  typedef enum logic [1:0] {S_LOAD, S_ROW, S_OUT} state_t;

  // D[k][n], roughly 128 * orthonormal DCT-II basis
  localparam logic signed [7:0] D_TAB [8][8] = '{
    '{ 8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45},
    '{ 8'sd63,  8'sd53,  8'sd36,  8'sd12, -8'sd12, -8'sd36, -8'sd53, -8'sd63},
    '{ 8'sd59,  8'sd24, -8'sd24, -8'sd59, -8'sd59, -8'sd24,  8'sd24,  8'sd59},
    '{ 8'sd53, -8'sd12, -8'sd63, -8'sd36,  8'sd36,  8'sd63,  8'sd12, -8'sd53},
    '{ 8'sd45, -8'sd45, -8'sd45,  8'sd45,  8'sd45, -8'sd45, -8'sd45,  8'sd45},
    '{ 8'sd36, -8'sd63,  8'sd12,  8'sd53, -8'sd53, -8'sd12,  8'sd63, -8'sd36},
    '{ 8'sd24, -8'sd59,  8'sd59, -8'sd24, -8'sd24,  8'sd59, -8'sd59,  8'sd24},
    '{ 8'sd12, -8'sd36,  8'sd53, -8'sd63,  8'sd63, -8'sd53,  8'sd36, -8'sd12}
  };

  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                     input int sh);
    return (v + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

endpackage

// File: rtl/idct8_dot.sv
// Combinational 8-term signed dot product against one column of D,
// followed by the rounding right-shift.
module idct8_dot
  import idct_pkg::*;
#(
  parameter int TW    = 23,
  parameter int SHIFT = 7,
  parameter int RW    = TW + 4
) (
  input  logic signed [TW-1:0] x [8],
  input  logic        [2:0]    col,
  output logic signed [RW-1:0] y
);

  // products are TW+8 bits; three guard bits cover the 8-way sum
  localparam int SW = TW + 11;

  logic signed [SW-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      acc = acc + (SW'(x[i]) * SW'(D_TAB[i][col]));
    end
    y = RW'(round_shift(64'(acc), SHIFT));
  end

endmodule

// File: rtl/idct8x8_seq.sv
// Serial 8x8 inverse DCT (X = D^T * Y * D) built around one shared dot unit.
// Optional JPEG level shift to unsigned pixels: define IDCT_LEVEL_SHIFT_EN.
module idct8x8_seq
  import idct_pkg::*;
#(
  parameter int IN_W  = 20,
  parameter int OUT_W = 8,
  parameter int SHIFT = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    done
);

  localparam int TW = IN_W + 3;
  localparam int RW = TW + 4;

  state_t state, state_nxt;
  logic [2:0] k_cnt, r_cnt, n_cnt;
  logic [5:0] idx, cidx;
  logic in_fire, out_fire;

  logic signed [IN_W-1:0] rowbuf [8];
  logic signed [TW-1:0]   tbuf   [8][8];
  logic signed [TW-1:0]   dot_x  [8];
  logic        [2:0]      dot_col;
  logic signed [RW-1:0]   dot_y;

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [RW-1:0] v);
    logic signed [RW:0] t;
`ifdef IDCT_LEVEL_SHIFT_EN
    localparam logic signed [RW:0] LO = '0;
    localparam logic signed [RW:0] HI = (RW+1)'((2 ** OUT_W) - 1);
    t = (RW+1)'(v) + (RW+1)'(2 ** (OUT_W - 1));
`else
    localparam logic signed [RW:0] LO = -(RW+1)'(2 ** (OUT_W - 1));
    localparam logic signed [RW:0] HI = (RW+1)'((2 ** (OUT_W - 1)) - 1);
    t = (RW+1)'(v);
`endif
    if (t < LO)      return LO[OUT_W-1:0];
    else if (t > HI) return HI[OUT_W-1:0];
    else             return t[OUT_W-1:0];
  endfunction

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  // sample to compute: idx 0 on entry, otherwise the one after the current
  assign cidx     = out_valid ? idx + 6'd1 : 6'd0;

  always_comb begin
    dot_col = n_cnt;
    for (int i = 0; i < 8; i++) dot_x[i] = TW'(rowbuf[i]);
    if (state != S_ROW) begin
      dot_col = cidx[5:3];
      for (int i = 0; i < 8; i++) dot_x[i] = tbuf[i][cidx[2:0]];
    end
  end

  idct8_dot #(.TW(TW), .SHIFT(SHIFT), .RW(RW)) u_dot (
    .x  (dot_x),
    .col(dot_col),
    .y  (dot_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD: if (in_fire && k_cnt == 3'd7) state_nxt = S_ROW;
      S_ROW:  if (n_cnt == 3'd7) state_nxt = (r_cnt == 3'd7) ? S_OUT : S_LOAD;
      S_OUT:  if (out_fire && idx == 6'd63) state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready = (state == S_LOAD);
    done     = (state == S_OUT) && out_fire && (idx == 6'd63);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_cnt     <= '0;
      r_cnt     <= '0;
      n_cnt     <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        S_LOAD: if (in_fire) k_cnt <= k_cnt + 3'd1;
        S_ROW: begin
          n_cnt <= n_cnt + 3'd1;
          if (n_cnt == 3'd7 && r_cnt != 3'd7) r_cnt <= r_cnt + 3'd1;
        end
        S_OUT: begin
          if (!out_valid) begin
            out_data  <= sat(dot_y);
            out_valid <= 1'b1;
            idx       <= '0;
          end else if (out_fire) begin
            if (idx == 6'd63) begin
              out_valid <= 1'b0;
              r_cnt     <= '0;
            end else begin
              out_data <= sat(dot_y);
              idx      <= idx + 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // buffers carry no reset; every entry is rewritten before it is read
  always_ff @(posedge clk) begin
    if (in_fire) rowbuf[k_cnt] <= in_data;
    if (state == S_ROW) tbuf[r_cnt][n_cnt] <= dot_y[TW-1:0];
  end

endmodule

// File: tb/tb_idct8x8_seq.sv
// Directed bench for idct8x8_seq: reference 2-D IDCT model plus a scoreboard
// checking every output handshake, hold-under-stall and done timing.
module tb_idct8x8_seq;

  localparam int DT [8][8] = '{
    '{45, 45, 45, 45, 45, 45, 45, 45},
    '{63, 53, 36, 12, -12, -36, -53, -63},
    '{59, 24, -24, -59, -59, -24, 24, 59},
    '{53, -12, -63, -36, 36, 63, 12, -53},
    '{45, -45, -45, 45, 45, -45, -45, 45},
    '{36, -63, 12, 53, -53, -12, 63, -36},
    '{24, -59, 59, -24, -24, 59, -59, 24},
    '{12, -36, 53, -63, 63, -53, 36, -12}
  };

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, done;
  logic signed [19:0] in_data;
  logic signed [7:0]  out_data;

  int n_vec = 0;
  int n_fail = 0;
  int exp_q[$];
  int blk_cnt = 0;
  bit bp_en = 0;
  bit prev_stall = 0;
  logic signed [7:0] prev_data;

  idct8x8_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int sample_val();
`ifdef IDCT_LEVEL_SHIFT_EN
    return int'($unsigned(out_data));
`else
    return int'(out_data);
`endif
  endfunction

  function automatic void model(input int y[64], output int x[64]);
    longint t[8][8];
    longint s;
    for (int r = 0; r < 8; r++)
      for (int n = 0; n < 8; n++) begin
        s = 0;
        for (int k = 0; k < 8; k++) s += longint'(y[r*8+k]) * DT[k][n];
        t[r][n] = (s + 64) >>> 7;
      end
    for (int m = 0; m < 8; m++)
      for (int n = 0; n < 8; n++) begin
        s = 0;
        for (int r = 0; r < 8; r++) s += longint'(DT[r][m]) * t[r][n];
        s = (s + 64) >>> 7;
`ifdef IDCT_LEVEL_SHIFT_EN
        s += 128;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
`else
        if (s < -128) s = -128;
        if (s > 127) s = 127;
`endif
        x[m*8+n] = int'(s);
      end
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // scoreboard: every handshake, stall hold, done alignment
  always @(negedge clk) begin
    if (reset) prev_stall = 0;
    else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL extra_transfer: got sample %0d, none expected", sample_val());
        end else check("sample", sample_val(), exp_q.pop_front());
        check("done", done, int'(blk_cnt == 63));
        blk_cnt = (blk_cnt == 63) ? 0 : blk_cnt + 1;
      end else if (done) check("done_idle", done, 0);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic send_block(input int y[64]);
    int w;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      in_data  = 20'(y[i]);
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (w >= 200) begin
        check("in_ready_timeout", w, 8);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      if (i % 8 == 0 && i > 0) check("in_ready_low_cycles", w, 8);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 3000) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
  endtask

  task automatic run_case(input int y[64], input bit bp);
    int x[64];
    model(y, x);
    for (int i = 0; i < 64; i++) exp_q.push_back(x[i]);
    bp_en = bp;
    send_block(y);
    wait_drain();
    bp_en = 0;
  endtask

  initial begin
    int zero[64], c1[64], c2[64], cmax[64], cmin[64], x[64];
    int row2[8];
    int c;
    row2 = '{44, 37, 25, 8, -8, -25, -37, -44};
    for (int i = 0; i < 64; i++) begin
      zero[i] = 0; c1[i] = 0; c2[i] = 0; cmax[i] = 0; cmin[i] = 0;
    end
    c1[0] = 512; c2[1] = 256; cmax[0] = 524287; cmin[0] = -524288;

    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_done", done, 0);
    @(posedge clk); #2; reset = 1'b0;

    model(c1, x);
    check("model_dc_0", x[0], 63);
    check("model_dc_63", x[63], 63);
    model(c2, x);
    for (int n = 0; n < 8; n++) check("model_ac_row3", x[24+n], row2[n]);
    model(cmax, x);
`ifdef IDCT_LEVEL_SHIFT_EN
    check("model_max", x[9], 255);
    model(cmin, x);
    check("model_min", x[9], 0);
`else
    check("model_max", x[9], 127);
    model(cmin, x);
    check("model_min", x[9], -128);
`endif

    run_case(zero, 0);
    run_case(c1, 0);
    run_case(c2, 0);
    run_case(c2, 1);
    run_case(cmax, 0);
    run_case(cmin, 0);

    model(c1, x);
    for (int i = 0; i < 64; i++) exp_q.push_back(x[i]);
    send_block(c1);
    c = 0;
    while (blk_cnt < 10 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 3000) check("reset_wait_timeout", blk_cnt, 10);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    blk_cnt = 0;
    @(posedge clk); #1;
    check("midrst_out_valid_hold", out_valid, 0);
    check("midrst_in_ready_hold", in_ready, 1);
    #1;
    reset = 1'b0;
    run_case(c1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
